// File: rtl/vram_arbiter.sv
// VRAM port arbiter: VGA scan-out reads win the single RAM port, while CPU writes wait in a FIFO.
// A starvation counter forces a write slot, and the preempted read is then reported as a miss.
module vram_arbiter #(
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_we,
  input  logic [14:0]   cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          wq_full,
  output logic          wq_empty,
  output logic [AW:0]   wq_count,
  output logic          wr_drop,
  input  logic          vga_rdn,
  input  logic [9:0]    vx,
  input  logic [9:0]    vy,
  output logic [7:0]    vga_dout,
  output logic          vga_dvalid,
  output logic          vga_miss,
  output logic [14:0]   ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t        state, next_state;
  logic [22:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [WW-1:0] wait_cnt;
  logic          push, pop, in_range, rd_hit, force_wr, miss_now;
  logic [14:0]   rd_addr;
  logic [22:0]   head;
  logic          p1_oor, p1_miss, p2_rd, p2_oor, p2_miss;

  assign wq_full  = (count == FULL_CNT);
  assign wq_empty = (count == '0);
  assign wq_count = count;
  assign head     = mem[rd_ptr];

  // 160x120 frame: vy/4 * 160 + vx/4
  assign rd_addr  = 15'({7'd0, vy[9:2]}) * 15'd160 + {7'd0, vx[9:2]};
  assign in_range = (vx < 10'd640) && (vy < 10'd480);
  assign rd_hit   = !vga_rdn && in_range;
  assign force_wr = (wait_cnt == WAIT_MAX) && !wq_empty;
  assign push     = cpu_we && !wq_full;
  assign pop      = (next_state == S_WR);

  always_comb begin
    next_state = S_IDLE;
    miss_now   = 1'b0;
    if (force_wr) begin
      next_state = S_WR;
      miss_now   = rd_hit;
    end else if (rd_hit) begin
      next_state = S_RD;
    end else if (!wq_empty) begin
      next_state = S_WR;
    end else begin
      next_state = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ram_addr <= 15'd0;
      ram_we   <= 1'b0;
      ram_din  <= 8'd0;
    end else begin
      state <= next_state;
      case (next_state)
        S_RD: begin
          ram_addr <= rd_addr;
          ram_we   <= 1'b0;
        end
        S_WR: begin
          ram_addr <= head[22:8];
          ram_din  <= head[7:0];
          ram_we   <= 1'b1;
        end
        default: ram_we <= 1'b0;
      endcase
    end
  end

  // Queue storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cpu_addr, cpu_din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
      wr_drop  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (cpu_we && wq_full) wr_drop <= 1'b1;
      if (wq_empty || pop)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Two-stage return pipeline: the RAM samples ram_addr one edge later, its data arrives the edge after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_oor     <= 1'b0;
      p1_miss    <= 1'b0;
      p2_rd      <= 1'b0;
      p2_oor     <= 1'b0;
      p2_miss    <= 1'b0;
      vga_dvalid <= 1'b0;
      vga_miss   <= 1'b0;
      vga_dout   <= 8'd0;
    end else begin
      p1_oor     <= !vga_rdn && !in_range;
      p1_miss    <= miss_now;
      p2_rd      <= (state == S_RD);
      p2_oor     <= p1_oor;
      p2_miss    <= p1_miss;
      vga_dvalid <= p2_rd || p2_oor;
      vga_miss   <= p2_miss;
      if (p2_rd)
        vga_dout <= ram_dout;
      else if (p2_oor)
        vga_dout <= 8'h00;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: vector table for reset/address/write paths,
// hand-written sequences for starvation, overflow and mid-operation reset.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_we = 1'b0;
  logic [14:0] cpu_addr = 15'd0;
  logic [7:0]  cpu_din = 8'd0;
  logic        wq_full, wq_empty, wr_drop;
  logic [2:0]  wq_count;
  logic        vga_rdn = 1'b1;
  logic [9:0]  vx = 10'd0, vy = 10'd0;
  logic [7:0]  vga_dout;
  logic        vga_dvalid, vga_miss;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = 8'd0;

  int checks = 0;
  int errors = 0;
  logic [7:0]  ram_m [32768];
  logic [22:0] wlog [$];

  vram_arbiter #(.DEPTH(4), .AW(2), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .wq_full(wq_full), .wq_empty(wq_empty), .wq_count(wq_count), .wr_drop(wr_drop),
    .vga_rdn(vga_rdn), .vx(vx), .vy(vy), .vga_dout(vga_dout), .vga_dvalid(vga_dvalid),
    .vga_miss(vga_miss), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // VRAM primitive model: synchronous write, synchronous read with 1-cycle latency.
  always @(posedge clk) begin
    if (ram_we) ram_m[ram_addr] <= ram_din;
    ram_dout <= ram_m[ram_addr];
  end

  typedef struct {
    logic        r, we;
    logic [14:0] a;
    logic [7:0]  d;
    logic        rdn;
    logic [9:0]  x, y;
    logic [39:0] exp;
  } vec_t;

  vec_t vt [18];

  function automatic logic [39:0] pack_exp(input logic we, input logic [14:0] addr, input logic [7:0] din,
                                           input logic dv, input logic [7:0] dout, input logic miss,
                                           input logic [2:0] cnt, input logic full, input logic empty,
                                           input logic drop);
    return {we, addr, din, dv, dout, miss, cnt, full, empty, drop};
  endfunction

  function automatic vec_t mk(input logic r, input logic we, input logic [14:0] a, input logic [7:0] d,
                              input logic rdn, input logic [9:0] x, input logic [9:0] y,
                              input logic [39:0] exp);
    vec_t v;
    v.r = r; v.we = we; v.a = a; v.d = d; v.rdn = rdn; v.x = x; v.y = y; v.exp = exp;
    return v;
  endfunction

  function automatic logic [39:0] actual();
    return {ram_we, ram_addr, ram_din, vga_dvalid, vga_dout, vga_miss, wq_count, wq_full, wq_empty, wr_drop};
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [14:0] a, input logic [7:0] d,
                      input logic rdn, input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    rst = r; cpu_we = we; cpu_addr = a; cpu_din = d; vga_rdn = rdn; vx = x; vy = y;
    @(posedge clk);
    #1;
    if (ram_we) wlog.push_back({ram_addr, ram_din});
  endtask

  initial begin
    logic [39:0] a0;
    int drain;
    for (int i = 0; i < 32768; i++) ram_m[i] = 8'h00;
    ram_m[19199] = 8'hA5;
    ram_m[0]     = 8'h3C;

    vt[0]  = mk(1'b1, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0, pack_exp(1'b0, 15'd0, 8'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[1]  = mk(1'b1, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0, pack_exp(1'b0, 15'd0, 8'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[2]  = mk(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0, pack_exp(1'b0, 15'd0, 8'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[3]  = mk(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0, pack_exp(1'b0, 15'd0, 8'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[4]  = mk(1'b0, 1'b0, 15'd0, 8'd0, 1'b0, 10'd639, 10'd479, pack_exp(1'b0, 15'd19199, 8'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[5]  = mk(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0, pack_exp(1'b0, 15'd19199, 8'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[6]  = mk(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0, pack_exp(1'b0, 15'd19199, 8'd0, 1'b1, 8'hA5, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[7]  = mk(1'b0, 1'b0, 15'd0, 8'd0, 1'b0, 10'd640, 10'd0, pack_exp(1'b0, 15'd19199, 8'd0, 1'b0, 8'hA5, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[8]  = mk(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0, pack_exp(1'b0, 15'd19199, 8'd0, 1'b0, 8'hA5, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[9]  = mk(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0, pack_exp(1'b0, 15'd19199, 8'd0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[10] = mk(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0, pack_exp(1'b0, 15'd19199, 8'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[11] = mk(1'b0, 1'b1, 15'h0123, 8'h5C, 1'b1, 10'd0, 10'd0, pack_exp(1'b0, 15'd19199, 8'd0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0));
    vt[12] = mk(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0, pack_exp(1'b1, 15'h0123, 8'h5C, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[13] = mk(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0, pack_exp(1'b0, 15'h0123, 8'h5C, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[14] = mk(1'b0, 1'b0, 15'd0, 8'd0, 1'b0, 10'd524, 10'd4, pack_exp(1'b0, 15'h0123, 8'h5C, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[15] = mk(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0, pack_exp(1'b0, 15'h0123, 8'h5C, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[16] = mk(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0, pack_exp(1'b0, 15'h0123, 8'h5C, 1'b1, 8'h5C, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    vt[17] = mk(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0, pack_exp(1'b0, 15'h0123, 8'h5C, 1'b0, 8'h5C, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));

    for (int i = 0; i < 18; i++) begin
      step(vt[i].r, vt[i].we, vt[i].a, vt[i].d, vt[i].rdn, vt[i].x, vt[i].y);
      chk($sformatf("vec%0d", i), actual(), vt[i].exp);
    end

    // Starvation: one write queued behind continuous in-range reads of address 0.
    wlog.delete();
    for (int j = 0; j < 30; j++) begin
      logic [39:0] e;
      step(1'b0, (j == 0), 15'h0200, 8'h77, 1'b0, 10'd0, 10'd0);
      e = {(j == 16) ? 1'b1 : 1'b0,
           (j == 16) ? 15'h0200 : 15'h0000,
           (j >= 16) ? 8'h77 : 8'h5C,
           (j >= 2 && j != 18) ? 1'b1 : 1'b0,
           (j >= 2) ? 8'h3C : 8'h5C,
           (j == 18) ? 1'b1 : 1'b0,
           (j < 16) ? 3'd1 : 3'd0,
           1'b0,
           (j < 16) ? 1'b0 : 1'b1,
           1'b0};
      chk($sformatf("starve%0d", j), actual(), e);
    end
    for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0);
    chk("starve_ram", {32'd0, ram_m[15'h0200]}, {32'd0, 8'h77});
    chk("starve_wcount", 40'(wlog.size()), 40'd1);

    // Overflow: five pushes into a four-entry queue while reads hog the port.
    wlog.delete();
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 1'b1, 15'h0300 + 15'(j), 8'(j + 1), 1'b0, 10'd0, 10'd0);
      if (j == 3) chk("ovf_full", {37'd0, wq_count}, {37'd0, 3'd4});
      if (j == 3) chk("ovf_nodrop", {38'd0, wq_full, wr_drop}, {38'd0, 1'b1, 1'b0});
      if (j == 4) chk("ovf_drop", {35'd0, wq_count, wq_full, wr_drop}, {35'd0, 3'd4, 1'b1, 1'b1});
    end
    for (int j = 0; j < 90; j++) step(1'b0, 1'b0, 15'd0, 8'd0, 1'b0, 10'd0, 10'd0);
    for (int j = 0; j < 10; j++) step(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0);
    chk("ovf_nwrites", 40'(wlog.size()), 40'd4);
    drain = (wlog.size() < 4) ? wlog.size() : 4;
    for (int j = 0; j < drain; j++)
      chk($sformatf("ovf_wr%0d", j), {17'd0, wlog[j]}, {17'd0, 15'h0300 + 15'(j), 8'(j + 1)});
    chk("ovf_sticky", {38'd0, wr_drop, wq_empty}, {38'd0, 1'b1, 1'b1});

    // Reset mid-operation: three queued writes and reads in flight.
    wlog.delete();
    for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 15'h0400 + 15'(j), 8'hE0 + 8'(j), 1'b0, 10'd0, 10'd0);
    chk("mid_queued", {37'd0, wq_count}, {37'd0, 3'd3});
    step(1'b1, 1'b0, 15'd0, 8'd0, 1'b0, 10'd0, 10'd0);
    chk("mid_reset", actual(), pack_exp(1'b0, 15'd0, 8'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 10'd0, 10'd0);
      a0 = actual();
      chk($sformatf("mid_quiet%0d", j), {35'd0, ram_we, vga_dvalid, vga_miss, wq_empty, wr_drop},
          {35'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    end
    chk("mid_nowrites", 40'(wlog.size()), 40'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
